// File: rtl/hazard_interlock_unit.sv
// Purpose: pipeline interlock for load-use, multi-cycle divide, taken-branch flush and data-memory waits.
// Latency: hold/bubble/flush controls are combinational in the same cycle; state and stall counter update on the clock edge.
// Backpressure: mem_busy freezes the whole pipeline and the divide sequencer until memory is ready again.
module hazard_interlock_unit #(
    parameter int DIV_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_div,
    input  logic        ex_branch_taken,
    input  logic        mem_busy,
    output logic        pc_hold,
    output logic        ifid_hold,
    output logic        ifid_flush,
    output logic        idex_hold,
    output logic        idex_bubble,
    output logic        exmem_hold,
    output logic        exmem_bubble,
    output logic        memwb_bubble,
    output logic        div_done,
    output logic [31:0] stall_count
);

    typedef enum logic {
        IDLE     = 1'b0,
        DIV_BUSY = 1'b1
    } state_t;

    // Remaining divide cycles after the start cycle; the start cycle itself is the first stall.
    localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

    state_t      state, state_nxt;
    logic [7:0]  div_cnt, div_cnt_nxt;
    logic [31:0] stall_cnt_q;
    logic        load_use;

    // Load-use needs a real destination (x0 never carries a dependency) matching an operand actually read.
    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_rs1_used && (id_rs1 == ex_rd)) ||
                       (id_rs2_used && (id_rs2 == ex_rd)));

    // Priority-ordered hazard resolution; higher rules mask lower ones, everything is quiet during reset.
    always_comb begin
        pc_hold      = 1'b0;
        ifid_hold    = 1'b0;
        ifid_flush   = 1'b0;
        idex_hold    = 1'b0;
        idex_bubble  = 1'b0;
        exmem_hold   = 1'b0;
        exmem_bubble = 1'b0;
        memwb_bubble = 1'b0;
        div_done     = 1'b0;
        state_nxt    = state;
        div_cnt_nxt  = div_cnt;
        if (reset) begin
            state_nxt   = IDLE;
            div_cnt_nxt = 8'd0;
        end else if (mem_busy) begin
            // Freeze everything up to MEM; MEM re-executes, so WB must not see a result yet.
            pc_hold      = 1'b1;
            ifid_hold    = 1'b1;
            idex_hold    = 1'b1;
            exmem_hold   = 1'b1;
            memwb_bubble = 1'b1;
        end else if (state == IDLE && ex_div) begin
            pc_hold      = 1'b1;
            ifid_hold    = 1'b1;
            idex_hold    = 1'b1;
            exmem_bubble = 1'b1;
            state_nxt    = DIV_BUSY;
            div_cnt_nxt  = DIV_LOAD;
        end else if (state == DIV_BUSY && div_cnt > 8'd1) begin
            pc_hold      = 1'b1;
            ifid_hold    = 1'b1;
            idex_hold    = 1'b1;
            exmem_bubble = 1'b1;
            div_cnt_nxt  = div_cnt - 8'd1;
        end else if (state == DIV_BUSY) begin
            // Last divide cycle: result is ready, let the pipeline advance.
            div_done    = 1'b1;
            state_nxt   = IDLE;
            div_cnt_nxt = 8'd0;
        end else if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
        end
    end

    // Divide sequencer state and counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            div_cnt <= 8'd0;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_cnt_nxt;
        end
    end

    // Stall-cycle performance counter, wraps naturally at 32 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else if (pc_hold) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_interlock_unit.sv
// Directed bench for hazard_interlock_unit with DIV_CYCLES=4.
// A driver issues one input vector per cycle and queues the expected controls; a monitor checks them at the falling edge.
module tb_hazard_interlock_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic        id_rs1_used = 1'b0, id_rs2_used = 1'b0;
    logic        ex_mem_read = 1'b0, ex_div = 1'b0, ex_branch_taken = 1'b0, mem_busy = 1'b0;
    logic        pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble;
    logic        exmem_hold, exmem_bubble, memwb_bubble, div_done;
    logic [31:0] stall_count;

    hazard_interlock_unit #(.DIV_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_div(ex_div),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
        .idex_hold(idex_hold), .idex_bubble(idex_bubble),
        .exmem_hold(exmem_hold), .exmem_bubble(exmem_bubble),
        .memwb_bubble(memwb_bubble), .div_done(div_done),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Control vector order: pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble,
    //                       exmem_hold, exmem_bubble, memwb_bubble, div_done
    localparam logic [8:0] NONE = 9'h000;
    localparam logic [8:0] LU   = 9'h190;
    localparam logic [8:0] DIVS = 9'h1A4;
    localparam logic [8:0] MEMB = 9'h1AA;
    localparam logic [8:0] BR   = 9'h050;
    localparam logic [8:0] DONE = 9'h001;

    typedef struct {
        logic [8:0]  ctl;
        logic [31:0] cnt;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: one expected entry per issued cycle, compared mid-cycle.
    initial begin
        exp_t       e;
        logic [8:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble,
                       exmem_hold, exmem_bubble, memwb_bubble, div_done};
                checks++;
                if (act !== e.ctl || stall_count !== e.cnt) begin
                    errors++;
                    $display("FAIL %s: got ctl=%h stall_count=%h, expected ctl=%h stall_count=%h",
                             e.nm, act, stall_count, e.ctl, e.cnt);
                end
            end
        end
    end

    task automatic step(input logic rst, input logic div, input logic mrd, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                        input logic br, input logic mb,
                        input logic [8:0] ctl, input logic [31:0] cnt, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; ex_div = div; ex_mem_read = mrd; ex_rd = rd;
        id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        ex_branch_taken = br; mem_busy = mb;
        e.ctl = ctl; e.cnt = cnt; e.nm = nm;
        exp_q.push_back(e);
    endtask

    // Stimulus: hand-computed expected controls and stall counts for each cycle.
    initial begin
        //    rst div mrd rd rs1 u1 rs2 u2 br mb  expected
        step(1, 0, 1, 5, 0, 0, 5, 1, 0, 1, NONE, 0, "reset_gates_outputs");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0, "idle_after_reset");
        // Load-use on rs2, then release
        step(0, 0, 1, 5, 0, 0, 5, 1, 0, 0, LU,   0, "loaduse_rs2");
        step(0, 0, 0, 5, 0, 0, 5, 1, 0, 0, NONE, 1, "loaduse_release");
        // x0 destination never stalls
        step(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, NONE, 1, "loaduse_rd0");
        // Load-use on rs1, then same regs but rs1 unused
        step(0, 0, 1, 7, 7, 1, 0, 0, 0, 0, LU,   1, "loaduse_rs1");
        step(0, 0, 1, 7, 7, 0, 0, 0, 0, 0, NONE, 2, "rs1_unused");
        // Divide: 3 stall cycles then done
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, DIVS, 2, "div_c1");
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, DIVS, 3, "div_c2");
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, DIVS, 4, "div_c3");
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, DONE, 5, "div_c4_done");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 5, "div_after");
        // Divide stretched by two mem_busy cycles starting at divide cycle 2
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, DIVS, 5, "divmb_c1");
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, MEMB, 6, "divmb_c2_busy");
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, MEMB, 7, "divmb_c3_busy");
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, DIVS, 8, "divmb_c4");
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, DIVS, 9, "divmb_c5");
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, DONE, 10, "divmb_c6_done");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 10, "divmb_after");
        // Branch beats a concurrent load-use pattern
        step(0, 0, 1, 3, 3, 1, 0, 0, 1, 0, BR,   10, "branch_over_loaduse");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 10, "branch_single_cycle");
        // mem_busy beats a branch
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, MEMB, 10, "membusy_over_branch");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 11, "membusy_release");
        // Reset in divide cycle 2, then a full new divide
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, DIVS, 11, "rstdiv_c1");
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0, "rstdiv_reset");
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, DIVS, 0, "rediv_c1");
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, DIVS, 1, "rediv_c2");
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, DIVS, 2, "rediv_c3");
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, DONE, 3, "rediv_c4_done");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 3, "rediv_after");
        // Counter wrap: preload all-ones, one more stall rolls it to zero
        @(posedge clk);
        #1;
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        step(0, 0, 1, 9, 9, 1, 0, 0, 0, 0, LU,   32'hFFFF_FFFF, "wrap_preloaded");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 32'h0000_0000, "wrap_to_zero");

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion before it");
        $fatal(1);
    end

endmodule

// File: doc/hazard_interlock_unit.md
# hazard_interlock_unit

Pipeline interlock controller for the RV32IM 5-stage core: the stalling counterpart of forwarding. It handles hazards that forwarding cannot resolve: load-use dependencies, the multi-cycle DIV/REM unit in EX, taken-branch flushes, and data-memory wait states. It drives hold and bubble/flush controls for the PC and every pipeline register, and keeps a stall-cycle performance counter.

## Interface
- DIV_CYCLES, 8, total EX occupancy of a DIV/DIVU/REM/REMU in cycles; legal range 2..255
- CLK  input  1  clock, all state updates on rising edge
- RESET  input  1  asynchronous, active-high reset
- ID_RS1  input  5  rs1 of instruction in ID
- ID_RS2  input  5  rs2 of instruction in ID
- ID_RS1_USED  input  1  ID instruction reads rs1
- ID_RS2_USED  input  1  ID instruction reads rs2
- EX_RD  input  5  rd of instruction in EX
- EX_MEM_READ  input  1  EX instruction is a load
- EX_DIV  input  1  EX instruction is a divide/remainder
- EX_BRANCH_TAKEN  input  1  EX resolved a taken branch/jump
- MEM_BUSY  input  1  data memory not ready; MEM access must repeat
- PC_HOLD  output  1  PC keeps value
- IFID_HOLD  output  1  IF/ID keeps value
- IFID_FLUSH  output  1  IF/ID loads NOP
- IDEX_HOLD  output  1  ID/EX keeps value
- IDEX_BUBBLE  output  1  ID/EX loads NOP
- EXMEM_HOLD  output  1  EX/MEM keeps value
- EXMEM_BUBBLE  output  1  EX/MEM loads NOP
- MEMWB_BUBBLE  output  1  MEM/WB loads NOP
- DIV_DONE  output  1  divide result valid in EX this cycle
- STALL_COUNT  output  32  cycles in which PC_HOLD=1

## Operation
- State: IDLE, DIV_BUSY; down-counter DIV_CNT (8 bit).
- Control outputs are combinational from state, DIV_CNT and inputs. All are forced to 0 while RESET=1.
- Priority, highest first. Lower rules are suppressed when a higher one fires:
  - **MEM_BUSY=1:** PC_HOLD, IFID_HOLD, IDEX_HOLD, EXMEM_HOLD and MEMWB_BUBBLE = 1. State and DIV_CNT are frozen. Nothing else is asserted.
  - **Divide start (IDLE and EX_DIV=1):** PC_HOLD, IFID_HOLD, IDEX_HOLD and EXMEM_BUBBLE = 1. Next state DIV_BUSY, DIV_CNT <= DIV_CYCLES-1.
  - **DIV_BUSY with DIV_CNT>1:** same four outputs as divide start. DIV_CNT decrements. EX_DIV is ignored.
  - **DIV_BUSY with DIV_CNT==1:** DIV_DONE=1, no hold (the pipeline advances). Next state IDLE, DIV_CNT <= 0.
  - **EX_BRANCH_TAKEN=1:** IFID_FLUSH=1 and IDEX_BUBBLE=1, no hold.
  - **Load-use:** condition is EX_MEM_READ=1, EX_RD≠0, and ((ID_RS1_USED and ID_RS1==EX_RD) or (ID_RS2_USED and ID_RS2==EX_RD)). Response is PC_HOLD, IFID_HOLD and IDEX_BUBBLE = 1.
- A divide start in the same cycle as DIV_DONE cannot occur, because EX holds one instruction. A new EX_DIV is seen only in the cycle after DIV_DONE.
- The branch, load-use and divide rules are mutually exclusive by construction: EX holds one instruction.
- HOLD and FLUSH/BUBBLE are never both 1 for the same register.
- STALL_COUNT increments by 1 on each rising edge where PC_HOLD=1. It wraps from 0xFFFFFFFF to 0.

## Timing
- Reset values:
  - state IDLE, DIV_CNT=0, STALL_COUNT=0.
  - Every control output and DIV_DONE = 0.
- Load-use: exactly 1 stall cycle. In the next cycle a bubble is in EX and EX_MEM_READ=0, so the stall releases and forwarding from MEM supplies the operand.
- Divide: PC_HOLD=1 for DIV_CYCLES-1 consecutive cycles, starting in the cycle EX_DIV first rises. DIV_DONE=1 in cycle DIV_CYCLES of the sequence. Each MEM_BUSY cycle lengthens the sequence by 1.
- Branch flush: single cycle, no stall.
- MEM_BUSY: the freeze lasts exactly as long as MEM_BUSY=1. Release on the first cycle MEM_BUSY=0.
- RESET mid-divide: state returns to IDLE and the counter clears immediately (asynchronous). STALL_COUNT clears.

## Test plan
- **Load-use:** EX_MEM_READ=1, EX_RD=5, ID_RS2=5, ID_RS2_USED=1 for 1 cycle, then EX_MEM_READ=0 → PC_HOLD, IFID_HOLD and IDEX_BUBBLE =1 for one cycle; STALL_COUNT goes 0→1. Repeat with EX_RD=0 → no stall.
- **Divide, DIV_CYCLES=4:** EX_DIV held at 1 → PC_HOLD/IDEX_HOLD/EXMEM_BUBBLE =1 for 3 cycles, DIV_DONE=1 in the 4th, STALL_COUNT=3.
- **Divide with MEM_BUSY:** MEM_BUSY=1 for 2 cycles during divide cycle 2 → DIV_DONE is delayed to cycle 6; MEMWB_BUBBLE=1 exactly in those 2 cycles.
- **Branch:** EX_BRANCH_TAKEN=1 with a load-use pattern also present on the ID inputs → IFID_FLUSH=1, IDEX_BUBBLE=1, PC_HOLD=0.
- **Reset mid-divide:** RESET pulsed in divide cycle 2 → all outputs 0 immediately, STALL_COUNT=0. A new EX_DIV after reset starts a full DIV_CYCLES sequence.
- **Wrap:** force 0xFFFFFFFF stall cycles (or preload via test hook) and assert one more PC_HOLD cycle → STALL_COUNT wraps to 0.
